// File: rtl/tug_field.sv
// Tug of War playfield: one lit LED moves one step per button press, and a win pulse fires when it is pulled past an edge.
// Define TUG_FIELD_SYNC_EN to put a 2-flop synchronizer on each button (two extra cycles of latency).
module tug_field #(
  parameter int N_LIGHTS    = 9,
  parameter int HOLD_CYCLES = 25_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                btn_l,
  input  logic                btn_r,
  output logic [N_LIGHTS-1:0] leds,
  output logic                win_l,
  output logic                win_r,
  output logic                holding
);

  localparam int PW = $clog2(N_LIGHTS);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [PW-1:0] CENTRE    = PW'((N_LIGHTS - 1) / 2);
  localparam logic [PW-1:0] LAST      = PW'(N_LIGHTS - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [N_LIGHTS-1:0] ONE = {{(N_LIGHTS-1){1'b0}}, 1'b1};

  typedef enum logic {PLAY, HOLD} state_t;

  state_t          state;
  logic [PW-1:0]   pos;
  logic [HW-1:0]   hold_cnt;
  logic            synced_l, synced_r;
  logic            prev_l, prev_r;
  logic            press_l, press_r;

`ifdef TUG_FIELD_SYNC_EN
  logic [1:0] sync_l, sync_r;

  // Synchronizers reset high so a button held through reset looks already-pressed.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_l <= 2'b11;
      sync_r <= 2'b11;
    end else begin
      sync_l <= {sync_l[0], btn_l};
      sync_r <= {sync_r[0], btn_r};
    end
  end

  assign synced_l = sync_l[1];
  assign synced_r = sync_r[1];
`else
  assign synced_l = btn_l;
  assign synced_r = btn_r;
`endif

  // Edge registers keep tracking in every state, so a button held through HOLD never fires on exit.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_l <= 1'b1;
      prev_r <= 1'b1;
    end else begin
      prev_l <= synced_l;
      prev_r <= synced_r;
    end
  end

  assign press_l = synced_l & ~prev_l;
  assign press_r = synced_r & ~prev_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= PLAY;
      pos      <= CENTRE;
      hold_cnt <= '0;
      leds     <= ONE << CENTRE;
      win_l    <= 1'b0;
      win_r    <= 1'b0;
      holding  <= 1'b0;
    end else begin
      win_l <= 1'b0;
      win_r <= 1'b0;
      case (state)
        PLAY: begin
          if (press_l && !press_r) begin
            if (pos == LAST) begin
              win_l    <= 1'b1;
              hold_cnt <= HOLD_LOAD;
              leds     <= '0;
              holding  <= 1'b1;
              state    <= HOLD;
            end else begin
              pos  <= pos + PW'(1);
              leds <= ONE << (pos + PW'(1));
            end
          end else if (press_r && !press_l) begin
            if (pos == '0) begin
              win_r    <= 1'b1;
              hold_cnt <= HOLD_LOAD;
              leds     <= '0;
              holding  <= 1'b1;
              state    <= HOLD;
            end else begin
              pos  <= pos - PW'(1);
              leds <= ONE << (pos - PW'(1));
            end
          end
        end
        HOLD: begin
          if (hold_cnt == '0) begin
            pos     <= CENTRE;
            leds    <= ONE << CENTRE;
            holding <= 1'b0;
            state   <= PLAY;
          end else begin
            hold_cnt <= hold_cnt - HW'(1);
          end
        end
        default: state <= PLAY;
      endcase
    end
  end

endmodule

// File: tb/tb_tug_field.sv
// Bench for tug_field: a game-level model checked every cycle, plus literal checkpoints.
module tb_tug_field;

  localparam int N = 9;
  localparam int H = 4;
  localparam int C = (N - 1) / 2;
`ifdef TUG_FIELD_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         btn_l, btn_r;
  logic [N-1:0] leds;
  logic         win_l, win_r, holding;

  int total = 0;
  int bad   = 0;
  int wl_cnt = 0;
  int wr_cnt = 0;
  int cycle = 0;

  tug_field #(.N_LIGHTS(N), .HOLD_CYCLES(H)) dut (
    .clk(clk), .reset(reset), .btn_l(btn_l), .btn_r(btn_r),
    .leds(leds), .win_l(win_l), .win_r(win_r), .holding(holding)
  );

  // clock / reset
  always #5 clk = ~clk;

  // game model: a button counts as pressed LAT edges after it is sampled high
  bit   model_valid = 0;
  int   m_pos;
  bit   m_hold;
  int   m_left;
  bit   m_wl, m_wr;
  bit   ql[$];
  bit   qr[$];
  bit   pl, pr;

  initial begin
    bit el, er, pressl, pressr;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_pos = C; m_hold = 0; m_left = 0; m_wl = 0; m_wr = 0;
        ql.delete(); qr.delete();
        for (int i = 0; i < LAT; i++) begin
          ql.push_back(1'b1);
          qr.push_back(1'b1);
        end
        pl = 1; pr = 1;
        model_valid = 1;
      end else begin
        ql.push_back(btn_l);
        qr.push_back(btn_r);
        el = ql.pop_front();
        er = qr.pop_front();
        pressl = el && !pl;
        pressr = er && !pr;
        pl = el; pr = er;
        m_wl = 0; m_wr = 0;
        if (m_hold) begin
          m_left--;
          if (m_left == 0) begin
            m_hold = 0;
            m_pos  = C;
          end
        end else if (pressl && !pressr) begin
          if (m_pos == N - 1) begin
            m_wl = 1; m_hold = 1; m_left = H;
          end else m_pos++;
        end else if (pressr && !pressl) begin
          if (m_pos == 0) begin
            m_wr = 1; m_hold = 1; m_left = H;
          end else m_pos--;
        end
      end
    end
  end

  // scoreboard: compare every cycle on the falling edge
  initial begin
    logic [N-1:0] one = 1;
    logic [N-1:0] exp_leds;
    forever begin
      @(negedge clk);
      cycle++;
      if (model_valid) begin
        exp_leds = m_hold ? '0 : (one << m_pos);
        total++;
        if (leds !== exp_leds || win_l !== m_wl || win_r !== m_wr || holding !== m_hold) begin
          bad++;
          $display("FAIL model cycle %0d: got leds=%h win_l=%b win_r=%b holding=%b, want leds=%h win_l=%b win_r=%b holding=%b",
                   cycle, leds, win_l, win_r, holding, exp_leds, m_wl, m_wr, m_hold);
        end
        if (win_l === 1'b1) wl_cnt++;
        if (win_r === 1'b1) wr_cnt++;
      end
    end
  end

  task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_l();
    btn_l = 1'b1; idle(3);
    btn_l = 1'b0; idle(3);
  endtask

  task automatic press_r();
    btn_r = 1'b1; idle(3);
    btn_r = 1'b0; idle(3);
  endtask

  // waits (bounded) for a win pulse on the selected side
  task automatic wait_win(input bit left, output bit seen);
    seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      if (left ? (win_l === 1'b1) : (win_r === 1'b1)) seen = 1;
    end
  endtask

  task automatic count_hold(output int n);
    n = 0;
    while (holding === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    bit seen;
    int hc;
    reset = 1'b1; btn_l = 1'b0; btn_r = 1'b0;
    idle(3);
    check_lit("reset_leds", 32'(leds), 32'h010);
    check_lit("reset_flags", {29'd0, win_l, win_r, holding}, 32'd0);
    reset = 1'b0;
    idle(2);

    press_l(); check_lit("step1", 32'(leds), 32'h020);
    press_l(); check_lit("step2", 32'(leds), 32'h040);
    press_l(); check_lit("step3", 32'(leds), 32'h080);
    press_l(); check_lit("step4", 32'(leds), 32'h100);

    btn_l = 1'b1;
    wait_win(1'b1, seen);
    check_lit("win_l_seen", 32'(seen), 32'd1);
    count_hold(hc);
    check_lit("hold_len", 32'(hc), 32'd4);
    check_lit("after_hold_leds", 32'(leds), 32'h010);
    btn_l = 1'b0;
    idle(4);
    check_lit("win_l_count1", 32'(wl_cnt), 32'd1);

    btn_l = 1'b1; idle(20);
    btn_l = 1'b0; idle(4);
    check_lit("held_one_move", 32'(leds), 32'h020);
    press_r();
    check_lit("back_centre", 32'(leds), 32'h010);

    btn_l = 1'b1; btn_r = 1'b1; idle(3);
    btn_l = 1'b0; btn_r = 1'b0; idle(4);
    check_lit("simul_no_move", 32'(leds), 32'h010);

    btn_l = 1'b1; idle(1);
    btn_l = 1'b0; btn_r = 1'b1; idle(1);
    btn_r = 1'b0; idle(5);
    check_lit("alternate", 32'(leds), 32'h010);

    press_r(); check_lit("r_step1", 32'(leds), 32'h008);
    press_r(); check_lit("r_step2", 32'(leds), 32'h004);
    press_r(); check_lit("r_step3", 32'(leds), 32'h002);
    press_r(); check_lit("r_step4", 32'(leds), 32'h001);
    btn_r = 1'b1;
    wait_win(1'b0, seen);
    check_lit("win_r_seen", 32'(seen), 32'd1);
    idle(10);
    btn_r = 1'b0;
    idle(6);
    check_lit("held_thru_hold", 32'(leds), 32'h010);
    check_lit("win_r_count", 32'(wr_cnt), 32'd1);

    press_l(); press_l(); press_l(); press_l();
    btn_l = 1'b1;
    wait_win(1'b1, seen);
    check_lit("win_l_seen2", 32'(seen), 32'd1);
    reset = 1'b1; btn_l = 1'b0;
    idle(1);
    check_lit("reset_in_hold_leds", 32'(leds), 32'h010);
    check_lit("reset_in_hold_flag", 32'(holding), 32'd0);
    reset = 1'b0;
    idle(10);
    check_lit("win_l_count2", 32'(wl_cnt), 32'd2);
    check_lit("final_leds", 32'(leds), 32'h010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    bad++;
    $display("FAIL timeout: bench did not finish in time");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
